// File: rtl/arb_pkg.sv
// Shared types, sizes and the round-robin search helper for bus_arbiter_8.
package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of mask at or after start, wrapping through index 0.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] mask,
                                    input logic [SEL_W-1:0] start);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p.found = 1'b0;
    p.idx   = start;
    for (int i = 0; i < N_REQ; i++) begin
      cand = start + SEL_W'(i);
      if (!p.found && mask[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_8_16.sv
// 8:1 mux of 16-bit words; select index is 4*s0 + 2*s1 + s2.
module mux_8_16
  import arb_pkg::*;
(
  input  logic              s0,
  input  logic              s1,
  input  logic              s2,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic [DATA_W-1:0] d4,
  input  logic [DATA_W-1:0] d5,
  input  logic [DATA_W-1:0] d6,
  input  logic [DATA_W-1:0] d7,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = d0;
    case ({s0, s1, s2})
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      3'd5:    y = d5;
      3'd6:    y = d6;
      3'd7:    y = d7;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter sharing one 16-bit bus among eight requesters.
// Define ARB_LOCK_EN to add the per-requester burst lock input.
module bus_arbiter_8
  import arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] din,
  output logic [N_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]        lock,
`endif
  output logic [CNT_W-1:0]        xfer_cnt
);

  state_e             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   last_q;
  logic               out_valid_q;
  logic [CNT_W-1:0]   xfer_cnt_q;
  logic [CNT_W-1:0]   xfer_cnt_d;
  logic [N_REQ-1:0]   pick_mask_s;
  logic [SEL_W-1:0]   pick_start_s;
  pick_t              pick_s;
  logic               keep_s;

  // While busy the current grant is masked: its req has not yet seen the grant drop.
  always_comb begin
    if (state_q == ST_BUSY) begin
      pick_mask_s  = req & ~gnt_q;
      pick_start_s = sel_q + 3'd1;
    end else begin
      pick_mask_s  = req;
      pick_start_s = last_q + 3'd1;
    end
    pick_s = rr_pick(pick_mask_s, pick_start_s);
  end

  assign xfer_cnt_d = xfer_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef ARB_LOCK_EN
  assign keep_s = lock[sel_q] & req[sel_q];
`else
  assign keep_s = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      sel_q       <= 3'd0;
      last_q      <= 3'd7;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q     <= ST_BUSY;
            gnt_q       <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_s.idx;
            sel_q       <= pick_s.idx;
            out_valid_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (out_ready) begin
            xfer_cnt_q <= xfer_cnt_d;
            last_q     <= sel_q;
            if (keep_s) begin
              state_q <= ST_BUSY;
            end else if (pick_s.found) begin
              gnt_q <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_s.idx;
              sel_q <= pick_s.idx;
            end else begin
              state_q     <= ST_IDLE;
              gnt_q       <= '0;
              out_valid_q <= 1'b0;
            end
          end else if (!req[sel_q]) begin
            // Withdrawal: nothing counted, last unchanged
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          gnt_q       <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = xfer_cnt_q;

  mux_8_16 u_mux (
    .s0 (sel_q[2]),
    .s1 (sel_q[1]),
    .s2 (sel_q[0]),
    .d0 (din[0*DATA_W +: DATA_W]),
    .d1 (din[1*DATA_W +: DATA_W]),
    .d2 (din[2*DATA_W +: DATA_W]),
    .d3 (din[3*DATA_W +: DATA_W]),
    .d4 (din[4*DATA_W +: DATA_W]),
    .d5 (din[5*DATA_W +: DATA_W]),
    .d6 (din[6*DATA_W +: DATA_W]),
    .d7 (din[7*DATA_W +: DATA_W]),
    .y  (out_data)
  );

endmodule

// File: doc/bus_arbiter_8.md
# bus_arbiter_8

Round-robin arbiter that shares one 16-bit output bus among eight requesters. It drives the select lines of an `mux_8_16` datapath instance and moves one word per granted handshake. It sits between eight producer blocks and a single downstream consumer.

## Interface
- `CNT_W`, default 16: width of the completed-transfer counter.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `req`  input  8  per-requester request; bit i is requester i.
- `din`  input  128  requester data, flattened; `din[16*i+15:16*i]` belongs to requester i.
- `gnt`  output  8  one-hot grant, or all-zero.
- `sel`  output  3  registered select `{s0,s1,s2}`; `s0` is the MSB. Mux index = 4·s0 + 2·s1 + s2.
- `out_valid`  output  1  output word valid.
- `out_data`  output  16  selected word.
- `out_ready`  input  1  consumer accepts the word.
- `xfer_cnt`  output  CNT_W  count of completed transfers; wraps.
- `lock`  input  8  per-requester burst lock. Present only with `ARB_LOCK_EN`.

## Operation
- **FSM with two states:**
  - `IDLE`: `gnt`=0, `out_valid`=0.
  - `BUSY`: exactly one `gnt` bit is set, `out_valid`=1.
- **Arbitration:**
  - Round-robin. The search starts at `(last+1) mod 8` and increments with wrap.
  - `last` is the index of the most recent completed transfer. Reset value is 7, so requester 0 has priority first.
- **IDLE → BUSY:** happens the cycle after `req`≠0. `gnt` and `sel` load the winner's index.
- **Transfer:** occurs in `BUSY` when `out_valid && out_ready`. On that edge:
  - `last` ← granted index.
  - `xfer_cnt` increments.
  - Arbitration runs immediately over `req` with the granted bit masked off. The granted bit is masked because the granted requester has not yet seen its grant drop.
  - If the masked `req` is nonzero, stay in `BUSY` with the new grant (back-to-back, one word per cycle). Otherwise go to `IDLE`.
- **Withdrawal:** if the granted requester drops `req` while in `BUSY` without a transfer:
  - Go to `IDLE` next cycle.
  - No transfer is counted and `last` is unchanged.
- **Data path:** `out_data` is the combinational mux output from `din` through `sel`. A requester must hold its data stable while granted.
- **Other requests:** new requests that arrive while another requester is granted wait. They never preempt.
- **Counter:** `xfer_cnt` is unsigned and wraps from 2^CNT_W−1 to 0.

## Timing
- **Reset values:** `gnt`=0, `sel`=3'b000, `out_valid`=0, `xfer_cnt`=0, `last`=7, state `IDLE`.
- **Reset assertion:** asynchronous. Mid-transfer reset drops `out_valid` immediately; the in-flight word is not counted.
- **Latency:** `req` rise → `gnt`/`out_valid` high at the next rising edge, a latency of 1 cycle.
- **Throughput:** 1 word/cycle when multiple requesters are pending and `out_ready`=1.
- **Backpressure:** while `out_ready`=0, `gnt`, `sel` and `out_data` are held.
- **Simultaneous transfer and withdrawal:** a transfer in the same cycle as the granted requester dropping `req` counts as a transfer.

## Configuration
- **`ARB_LOCK_EN` defined:**
  - `lock` port exists.
  - On a transfer, if `lock[granted]` and `req[granted]` are both 1, the grant is kept: there is no rearbitration and `last` is still updated.
  - The counter increments per beat.
- **`ARB_LOCK_EN` undefined:** there is no `lock` port and every transfer rearbitrates.

## Structure
- **Shared package `arb_pkg`:**
  - `N_REQ`=8, `DATA_W`=16, `SEL_W`=3.
  - State encoding `ST_IDLE`=1'b0, `ST_BUSY`=1'b1.
- **Sub-module:** instantiate `mux_8_16` as `u_mux`. Its ports map as s0←`sel[2]`, s1←`sel[1]`, s2←`sel[0]`, d0..d7←`din` slices, y→`out_data`.
- **Optional helper:** a combinational `rr_pick` function or sub-module, taking (`req` mask, start index) and returning (found, index).

## Test plan
- Reset, then `req`=8'h01, `din[15:0]`=16'hA5A5, `out_ready`=1 → next cycle `gnt`=8'h01, `sel`=0, `out_data`=16'hA5A5; after 1 transfer `xfer_cnt`=1.
- `req`=8'hFF held, `out_ready`=1 → grants 0,1,2,…,7,0 on consecutive cycles with no idle cycle; `sel` tracks the index.
- `req`=8'h30, `out_ready`=0 for 5 cycles → `gnt`=8'h10 held with `out_data` stable; `out_ready`=1 → transfer, then `gnt`=8'h20.
- Requester 3 granted drops `req` with `out_ready`=0 → `IDLE` next cycle, `xfer_cnt` unchanged; re-request grants 3 again.
- Assert `rst_n`=0 mid-burst → `gnt`=0 and `out_valid`=0 immediately; after release `req`=8'h80 with `req`=8'h01 → requester 0 wins.
- With `ARB_LOCK_EN`: `req`=8'h06, `lock`=8'h02 for 3 beats → three transfers from requester 1, then requester 2 is granted; `xfer_cnt`=4 after requester 2's transfer.
